block_serializer: RTL and testbench

Parametrised successor to the fixed 16×8 block streamer. It accepts a full block of `NUM_WORDS` words of `WORD_W` bits in one cycle over a valid/ready load handshake. It then emits the block one word per accepted beat over a valid/ready output stream, with last-word marking, selectable word order and a synchronous abort. It sits between block producers (cipher rounds, frame builders) and byte- or word-wide sinks such as UART/FIFO feeders.

---
 rtl/block_serializer.sv | 151 +++++++++++++++
 tb/tb_block_serializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/block_serializer.sv
// block_serializer: captures a NUM_WORDS x WORD_W block in one cycle and streams it
// one word per valid/ready beat, lsb- or msb-first, with last marking and abort.
// Define BLOCK_SERIALIZER_PINGPONG_EN to add a shadow block for zero-bubble streaming.
module block_serializer #(
    parameter int NUM_WORDS = 16,
    parameter int WORD_W    = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        load_valid_in,
    output logic                        load_ready_out,
    input  logic [NUM_WORDS*WORD_W-1:0] block_in,
    input  logic                        msb_first_in,
    input  logic                        abort_in,
    output logic [WORD_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready_in,
    output logic                        out_last,
    output logic                        busy_out
);
    localparam int IW = $clog2(NUM_WORDS);
    localparam int BW = NUM_WORDS * WORD_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [IW-1:0] ONE      = IW'(1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] active_q, active_d;
    logic          msb_q, msb_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] term_idx;
    logic          beat, end_beat, load_acc;
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
    logic [BW-1:0] shadow_q, shadow_d;
    logic          shadow_msb_q, shadow_msb_d;
    logic          shadow_full_q, shadow_full_d;
`endif

    // The terminal index follows the order bit of whichever block is active.
    assign term_idx = msb_q ? '0 : LAST_IDX;
    assign beat     = out_valid && out_ready_in;
    assign end_beat = beat && out_last;
    assign load_acc = load_valid_in && load_ready_out;
    // Output word is always taken from the registered active buffer, never from block_in.
    assign out_data = active_q[32'(idx_q) * WORD_W +: WORD_W];

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: load starts a stream, abort or a final beat without a follow-on block ends it.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            state_d = load_acc ? STREAM : IDLE;
        end else if (abort_in) begin
            state_d = IDLE;
        end else if (end_beat) begin
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
            state_d = (shadow_full_q || load_acc) ? STREAM : IDLE;
`else
            state_d = IDLE;
`endif
        end
    end

    // Outputs decoded from state, index and shadow occupancy.
    always_comb begin
        out_valid = (state_q == STREAM);
        busy_out  = out_valid;
        out_last  = out_valid && (idx_q == term_idx);
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
        load_ready_out = !shadow_full_q;
`else
        load_ready_out = (state_q == IDLE);
`endif
    end

    // Datapath registers: active block, its order bit and the word index.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active_q <= '0;
            msb_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            active_q <= active_d;
            msb_q    <= msb_d;
            idx_q    <= idx_d;
        end
    end

`ifdef BLOCK_SERIALIZER_PINGPONG_EN
    // Shadow block waiting behind the active one.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shadow_q      <= '0;
            shadow_msb_q  <= 1'b0;
            shadow_full_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            shadow_msb_q  <= shadow_msb_d;
            shadow_full_q <= shadow_full_d;
        end
    end
`endif

    // Index stepping, block capture and (optionally) shadow fill/promotion; abort wins over all.
    always_comb begin
        active_d = active_q;
        msb_d    = msb_q;
        idx_d    = idx_q;
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
        shadow_d      = shadow_q;
        shadow_msb_d  = shadow_msb_q;
        shadow_full_d = shadow_full_q;
`endif
        if (state_q == STREAM && abort_in) begin
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
            shadow_full_d = 1'b0;
`endif
        end else begin
            if (beat && !out_last) idx_d = msb_q ? idx_q - ONE : idx_q + ONE;
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
            if (end_beat && shadow_full_q) begin
                active_d      = shadow_q;
                msb_d         = shadow_msb_q;
                idx_d         = shadow_msb_q ? LAST_IDX : '0;
                shadow_full_d = 1'b0;
            end
`endif
            // A load while idle or on the final beat (shadow empty) goes straight to active.
            if (load_acc) begin
                if (state_q == IDLE || end_beat) begin
                    active_d = block_in;
                    msb_d    = msb_first_in;
                    idx_d    = msb_first_in ? LAST_IDX : '0;
                end
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
                else begin
                    shadow_d      = block_in;
                    shadow_msb_d  = msb_first_in;
                    shadow_full_d = 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_block_serializer.sv
// tb_block_serializer: directed checks of block_serializer with NUM_WORDS=16, WORD_W=8.
module tb_block_serializer;
    localparam int NW = 16;
    localparam int WW = 8;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              load_valid_in = 1'b0;
    logic              msb_first_in = 1'b0;
    logic              abort_in = 1'b0;
    logic              out_ready_in = 1'b0;
    logic [NW*WW-1:0]  block_in = '0;
    logic              load_ready_out, out_valid, out_last, busy_out;
    logic [WW-1:0]     out_data;

    int checks = 0;
    int passed = 0;

    block_serializer #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .load_valid_in(load_valid_in),
        .load_ready_out(load_ready_out), .block_in(block_in), .msb_first_in(msb_first_in),
        .abort_in(abort_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready_in(out_ready_in), .out_last(out_last), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [NW*WW-1:0] mk(input logic [7:0] base);
        logic [NW*WW-1:0] b;
        for (int i = 0; i < NW; i++) b[i*WW +: WW] = base + 8'(i);
        return b;
    endfunction

    task automatic load(input logic [7:0] base, input logic msb);
        chk("load_ready_idle", load_ready_out, 1);
        block_in      = mk(base);
        msb_first_in  = msb;
        load_valid_in = 1'b1;
        tick();
        load_valid_in = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_ready"}, load_ready_out, 1);
    endtask

    task automatic stream(input logic [7:0] base, input logic msb);
        for (int k = 0; k < NW; k++) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, base + 8'(msb ? NW - 1 - k : k));
            chk("stream_last", out_last, k == NW - 1);
            tick();
        end
        check_idle("stream_end");
    endtask

    initial begin
        logic [11:0] pat;
        int e;
        int beats;
        int bubbles;
        logic acc;

        // Reset values while rst_in is held
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", load_ready_out, 1);
        tick();
        rst_in = 1'b0;
        tick();
        check_idle("post_rst");

        // lsb-first, ready held high: 16 consecutive beats then idle
        out_ready_in = 1'b1;
        load(8'h00, 1'b0);
        stream(8'h00, 1'b0);

        // msb-first: 0x0F down to 0x00
        load(8'h00, 1'b1);
        stream(8'h00, 1'b1);

        // Sink stalls: words in order, held through stall cycles
        pat = 12'b1001_1010_0110;
        out_ready_in = 1'b0;
        load(8'h00, 1'b0);
        e = 0;
        for (int c = 0; c < 200 && e < NW; c++) begin
            out_ready_in = pat[c % 12];
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 8'(e));
            chk("stall_last", out_last, e == NW - 1);
            tick();
            if (out_ready_in) e++;
        end
        chk("stall_count", e, NW);
        out_ready_in = 1'b1;
        check_idle("stall_end");

        // Abort after the 5th beat, then a fresh block streams from 0xA0
        load(8'h00, 1'b0);
        repeat (5) tick();
        chk("pre_abort_data", out_data, 8'h05);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check_idle("abort");
        chk("abort_last", out_last, 0);
        load(8'hA0, 1'b0);
        stream(8'hA0, 1'b0);

        // Abort in IDLE is ignored
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check_idle("idle_abort");

        // Asynchronous reset at word 7
        load(8'h00, 1'b0);
        repeat (7) tick();
        chk("pre_rst_data", out_data, 8'h07);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_ready", load_ready_out, 1);
        tick();
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("post_rst_valid", out_valid, 0);
            chk("post_rst_data", out_data, 0);
            tick();
        end

        // Back-to-back blocks 0x00+i and 0x10+i, ready held high
        block_in      = mk(8'h00);
        msb_first_in  = 1'b0;
        load_valid_in = 1'b1;
        tick();
        block_in = mk(8'h10);
        beats    = 0;
        bubbles  = 0;
        for (int c = 0; c < 34; c++) begin
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
            chk("b2b_ready", load_ready_out, c == 0 || c >= 16);
`else
            chk("b2b_ready", load_ready_out, c == 16 || c >= 33);
`endif
            if (out_valid) begin
                chk("b2b_data", out_data, 8'(beats));
                chk("b2b_last", out_last, beats % NW == NW - 1);
                beats++;
            end else if (beats > 0 && beats < 2 * NW) begin
                bubbles++;
            end
            acc = load_valid_in && load_ready_out;
            tick();
            if (acc) load_valid_in = 1'b0;
        end
        chk("b2b_beats", beats, 2 * NW);
`ifdef BLOCK_SERIALIZER_PINGPONG_EN
        chk("b2b_bubbles", bubbles, 0);
`else
        chk("b2b_bubbles", bubbles, 1);
`endif
        check_idle("b2b_end");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
